// File: rtl/fifo_inst_sequencer.sv
// fifo_inst_sequencer
// Arbitrates host write and read requests into one {WE, RE, DI} instruction
// per cycle for a single-port FIFO. Tracks committed occupancy and reads that
// have been issued but not yet answered, so it never overfills or underflows
// the FIFO and never exceeds the allowed number of outstanding reads.
module fifo_inst_sequencer #(
    parameter int DEPTH    = 16,
    parameter int MAX_PEND = 4,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [31:0]      wr_data,
    output logic             wr_ready,
    input  logic             rd_valid,
    output logic             rd_ready,
    output logic [33:0]      inst,
    input  logic             read_valid,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic [2:0]       pend,
    output logic             err
);

    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [2:0]       MAX_PEND_C = 3'(MAX_PEND);

    logic [33:0]      inst_q,  inst_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       pend_q,  pend_d;
    logic             err_q,   err_d;
    logic             prio_q,  prio_d;

    logic wr_elig_s;
    logic rd_elig_s;
    logic wr_acc_s;
    logic rd_acc_s;
    logic rv_dec_s;
    logic contested_s;

    assign inst  = inst_q;
    assign count = count_q;
    assign pend  = pend_q;
    assign err   = err_q;
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == CNT_ZERO);

    // Eligibility, arbitration, readies and next-state for every register
    always_comb begin
        wr_elig_s   = (count_q != DEPTH_C);
        rd_elig_s   = (count_q != CNT_ZERO) && (pend_q < MAX_PEND_C);
        // The loser of a contested cycle is held off by the priority bit; the
        // winner's ready never depends on its own valid.
        wr_ready    = wr_elig_s && !(rd_valid && rd_elig_s && prio_q);
        rd_ready    = rd_elig_s && !(wr_valid && wr_elig_s && !prio_q);
        wr_acc_s    = wr_valid && wr_ready;
        rd_acc_s    = rd_valid && rd_ready;
        contested_s = wr_valid && wr_elig_s && rd_valid && rd_elig_s;
        rv_dec_s    = read_valid && (pend_q != 3'd0);

        prio_d = contested_s ? !prio_q : prio_q;

        if (wr_acc_s) begin
            inst_d = {1'b1, 1'b0, wr_data};
        end else if (rd_acc_s) begin
            inst_d = {1'b0, 1'b1, 32'h0000_0000};
        end else begin
            inst_d = 34'h0_0000_0000;
        end

        // Handshakes are mutually exclusive, so at most one step per edge
        if (wr_acc_s) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_acc_s) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end

        // A new read and a retiring read in the same cycle cancel out
        if (rd_acc_s && !rv_dec_s) begin
            pend_d = pend_q + 3'd1;
        end else if (!rd_acc_s && rv_dec_s) begin
            pend_d = pend_q - 3'd1;
        end else begin
            pend_d = pend_q;
        end

        // A response with nothing outstanding is a protocol violation by the FIFO
        err_d = err_q || (read_valid && (pend_q == 3'd0) && !rd_acc_s);
    end

    // State registers with synchronous reset that overrides any handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q  <= 34'h0_0000_0000;
            count_q <= CNT_ZERO;
            pend_q  <= 3'd0;
            err_q   <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            prio_q  <= prio_d;
        end
    end

endmodule

// File: tb/tb_fifo_inst_sequencer.sv
// Scoreboard bench for fifo_inst_sequencer: a queue-based reference model
// predicts readies, instructions and counters; a separate monitor checks every
// non-idle instruction against the expected-instruction queue.
module tb_fifo_inst_sequencer;

    localparam int DEPTH    = 16;
    localparam int MAX_PEND = 4;
    localparam int CNT_W    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_valid = 1'b0;
    logic [31:0]      wr_data = 32'h0;
    logic             wr_ready;
    logic             rd_valid = 1'b0;
    logic             rd_ready;
    logic [33:0]      inst;
    logic             read_valid = 1'b0;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic [2:0]       pend;
    logic             err;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_count = 0;
    int m_pend  = 0;
    int m_err   = 0;
    int m_prio  = 0;
    int n_reads = 0;
    logic [33:0] exp_q[$];

    fifo_inst_sequencer #(.DEPTH(DEPTH), .MAX_PEND(MAX_PEND)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .inst(inst), .read_valid(read_valid),
        .count(count), .full(full), .empty(empty),
        .pend(pend), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every issued instruction must match the oldest expected one
    always begin
        logic [33:0] e;
        @(posedge clk);
        #1;
        if (inst !== 34'h0) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL inst_unexpected: got %h expected none at %0t", inst, $time);
            end else begin
                e = exp_q.pop_front();
                if (inst !== e) begin
                    n_fail++;
                    $display("FAIL inst: got %h expected %h at %0t", inst, e, $time);
                end
            end
        end
    end

    // one clock cycle: drive, check readies, advance model, check counters
    task automatic cycle(input bit r, input bit wv, input logic [31:0] wd,
                         input bit rv, input bit rdv);
        bit w_elig, r_elig, want_w, want_r, gw, gr, dec;
        @(negedge clk);
        rst = r; wr_valid = wv; wr_data = wd; rd_valid = rv; read_valid = rdv;
        #1;
        w_elig = (m_count < DEPTH);
        r_elig = (m_count > 0) && (m_pend < MAX_PEND);
        want_w = wv && w_elig;
        want_r = rv && r_elig;
        chk("wr_ready", int'(wr_ready), int'(w_elig && !(want_r && m_prio == 1)));
        chk("rd_ready", int'(rd_ready), int'(r_elig && !(want_w && m_prio == 0)));
        gw = want_w && (!want_r || m_prio == 0);
        gr = want_r && (!want_w || m_prio == 1);
        if (r) begin
            m_count = 0; m_pend = 0; m_err = 0; m_prio = 0;
        end else begin
            if (want_w && want_r) m_prio = 1 - m_prio;
            dec = rdv && (m_pend > 0);
            if (rdv && m_pend == 0 && !gr) m_err = 1;
            if (gw) begin
                exp_q.push_back({2'b10, wd});
                m_count++;
            end
            if (gr) begin
                exp_q.push_back({2'b01, 32'h0000_0000});
                m_count--;
                n_reads++;
            end
            m_pend = m_pend + int'(gr) - int'(dec);
        end
        @(posedge clk);
        #2;
        chk("count", int'(count), m_count);
        chk("pend", int'(pend), m_pend);
        chk("err", int'(err), m_err);
        chk("full", int'(full), int'(m_count == DEPTH));
        chk("empty", int'(empty), int'(m_count == 0));
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        int r0;
        // reset then idle
        do_reset();
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("reset_inst", int'(inst == 34'h0), 1);
        chk("reset_count", int'(count), 0);
        chk("reset_empty", int'(empty), 1);

        // fill to full: 17 writes, the last one refused
        for (int i = 0; i < 17; i++) cycle(1'b0, 1'b1, 32'hA000_0000 + i, 1'b0, 1'b0);
        chk("fill_count", int'(count), 16);
        chk("fill_full", int'(full), 1);
        chk("fill_wr_ready", int'(wr_ready), 0);

        // contention at count 8, prio 0: W R W R
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 32'hB000_0000 + i, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 32'hC000_0000 + i, 1'b1, 1'b0);
        chk("cont_count", int'(count), 8);
        chk("cont_pend", int'(pend), 2);

        // pend limit at count 10
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 32'hD000_0000 + i, 1'b0, 1'b0);
        r0 = n_reads;
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("pend_limit_reads", n_reads - r0, 4);
        chk("pend_limit_rd_ready", int'(rd_ready), 0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("pend_refill_reads", n_reads - r0, 5);

        // empty guard: write wins at empty, read follows next cycle
        do_reset();
        cycle(1'b0, 1'b1, 32'hE000_0001, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("empty_guard_count", int'(count), 0);
        chk("empty_guard_pend", int'(pend), 1);

        // spurious response, then reset during a live handshake
        do_reset();
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("spurious_err", int'(err), 1);
        cycle(1'b0, 1'b1, 32'hF000_0000, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'hF000_0001, 1'b0, 1'b0);
        chk("midreset_count", int'(count), 0);
        chk("midreset_err", int'(err), 0);

        // randomized traffic with an emulated FIFO answering reads
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit wv, rv, rdv;
            wv  = ($urandom_range(0, 99) < 55);
            rv  = ($urandom_range(0, 99) < 50);
            rdv = (m_pend > 0 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 199) == 0);
            cycle(1'b0, wv, $urandom, rv, rdv);
        end

        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
